// File: rtl/uart_pkg.sv
// Shared types, constants and arithmetic helpers for the UART receive controller.
package uart_pkg;

  typedef enum logic [1:0] {
    BAUD_IDLE = 2'd0,
    BAUD_HALF = 2'd1,
    BAUD_RUN  = 2'd2
  } baud_state_e;

  localparam int unsigned UART_DIV_MIN = 16;
  localparam int unsigned UART_ENTRY_W = 9;
  localparam int unsigned UART_CNT_W   = 16;
  localparam int unsigned UART_DIV_W   = 16;

  typedef logic [UART_DIV_W-1:0] div_t;
  typedef logic [UART_CNT_W-1:0] cnt_t;

  function automatic div_t clamp_div(input div_t div, input div_t div_min);
    div_t res;
    if (div < div_min) begin
      res = div_min;
    end else begin
      res = div;
    end
    return res;
  endfunction

  // Half-bit delay shortened by the receiver's synchroniser latency, never below one cycle.
  function automatic div_t half_load(input div_t d, input div_t lat);
    div_t half;
    div_t res;
    half = d >> 1;
    if (half > lat) begin
      res = half - lat;
    end else begin
      res = 16'd1;
    end
    return res;
  endfunction

  function automatic cnt_t sat_inc(input cnt_t v);
    cnt_t res;
    if (v == 16'hFFFF) begin
      res = v;
    end else begin
      res = v + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-facing and consumer-facing signal bundle of the receive controller.
interface uart_rx_ctrl_if;
  import uart_pkg::*;

  logic                    rx_en;
  logic                    rx_clk_en;
  logic                    rx_clk;
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    rx_check_flag;
  logic                    rx_ready;
  logic [UART_ENTRY_W-1:0] rd_data;
  logic                    rd_valid;
  logic                    rd_ready;

  modport master (
    output rx_en, rx_clk, rx_ready, rd_data, rd_valid,
    input  rx_clk_en, rx_data, rx_valid, rx_check_flag, rd_ready
  );

  modport slave (
    input  rx_en, rx_clk, rx_ready, rd_data, rd_valid,
    output rx_clk_en, rx_data, rx_valid, rx_check_flag, rd_ready
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count and synchronous flush.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             rd_valid_r;
  logic             full_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign do_pop_s  = pop && rd_valid_r && !flush;
  assign do_push_s = push && !flush && (!full_r || do_pop_s);

  // Next occupancy; flush overrides any same-cycle push or pop.
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + CNT_W'(1'b1);
    end else if (do_pop_s && !do_push_s) begin
      count_nxt_s = count_r - CNT_W'(1'b1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      rd_valid_r <= 1'b0;
      full_r     <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      rd_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
      full_r     <= (count_nxt_s == CNT_W'(DEPTH));
      if (flush) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (do_push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
        end
        if (do_pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
        end
      end
    end
  end

  // Storage array; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign rd_data  = mem_r[rd_ptr_r];
  assign rd_valid = rd_valid_r;
  assign full     = full_r;
  assign count    = count_r;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: bit-centre strobe generation, byte FIFO drain and error statistics.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SYNC_LAT   = 4,
  parameter int unsigned DIV_MIN    = UART_DIV_MIN
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            flush,
  input  logic                            clr_stats,
  input  logic [UART_DIV_W-1:0]           baud_div,
  uart_rx_ctrl_if.master                  bus,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic [UART_CNT_W-1:0]           overrun_cnt,
  output logic [UART_CNT_W-1:0]           parity_err_cnt
);

  baud_state_e             state_r;
  div_t                    div_r;
  div_t                    baud_cnt_r;
  div_t                    div_clamp_s;
  div_t                    half_s;
  logic                    rx_clk_r;
  logic                    rx_en_r;
  cnt_t                    overrun_cnt_r;
  cnt_t                    parity_cnt_r;
  logic                    accept_s;
  logic                    pop_s;
  logic                    push_s;
  logic                    ovr_inc_s;
  logic                    par_inc_s;
  logic                    fifo_full_s;
  logic                    fifo_valid_s;
  logic [UART_ENTRY_W-1:0] fifo_data_s;

  assign div_clamp_s = clamp_div(baud_div, UART_DIV_W'(DIV_MIN));
  assign half_s      = half_load(div_clamp_s, UART_DIV_W'(SYNC_LAT));

  // Receiver enable is a registered copy of the block enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_en_r <= 1'b0;
    end else begin
      rx_en_r <= enable;
    end
  end

  // The receiver is never back-pressured: a full FIFO drops the byte instead.
  assign accept_s  = bus.rx_valid && rx_en_r;
  assign pop_s     = fifo_valid_s && bus.rd_ready;
  assign push_s    = accept_s && !flush && (!fifo_full_s || pop_s);
  assign ovr_inc_s = accept_s && !flush && fifo_full_s && !pop_s;
  assign par_inc_s = accept_s && bus.rx_check_flag;

  // Baud strobe generator: half-bit to the first centre, then one strobe per bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= BAUD_IDLE;
      div_r      <= 16'd0;
      baud_cnt_r <= 16'd0;
      rx_clk_r   <= 1'b0;
    end else begin
      rx_clk_r <= 1'b0;
      if (!bus.rx_clk_en) begin
        state_r    <= BAUD_IDLE;
        baud_cnt_r <= 16'd0;
      end else begin
        case (state_r)
          BAUD_IDLE: begin
            div_r      <= div_clamp_s;
            baud_cnt_r <= half_s;
            state_r    <= BAUD_HALF;
          end
          BAUD_HALF, BAUD_RUN: begin
            if (baud_cnt_r == 16'd1) begin
              rx_clk_r   <= 1'b1;
              baud_cnt_r <= div_r;
              state_r    <= BAUD_RUN;
            end else begin
              baud_cnt_r <= baud_cnt_r - 16'd1;
            end
          end
          default: begin
            state_r    <= BAUD_IDLE;
            baud_cnt_r <= 16'd0;
          end
        endcase
      end
    end
  end

  // Saturating error statistics; a clear beats a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt_r <= 16'd0;
      parity_cnt_r  <= 16'd0;
    end else if (clr_stats) begin
      overrun_cnt_r <= 16'd0;
      parity_cnt_r  <= 16'd0;
    end else begin
      if (ovr_inc_s) begin
        overrun_cnt_r <= sat_inc(overrun_cnt_r);
      end
      if (par_inc_s) begin
        parity_cnt_r <= sat_inc(parity_cnt_r);
      end
    end
  end

  uart_sync_fifo #(
    .WIDTH (UART_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push_s),
    .push_data ({bus.rx_check_flag, bus.rx_data}),
    .pop       (bus.rd_ready),
    .rd_data   (fifo_data_s),
    .rd_valid  (fifo_valid_s),
    .full      (fifo_full_s),
    .count     (fifo_count)
  );

  assign bus.rx_en    = rx_en_r;
  assign bus.rx_ready = rx_en_r;
  assign bus.rx_clk   = rx_clk_r;
  assign bus.rd_data  = fifo_data_s;
  assign bus.rd_valid = fifo_valid_s;
  assign overrun_cnt    = overrun_cnt_r;
  assign parity_err_cnt = parity_cnt_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: strobe timing, FIFO ordering, overrun/parity statistics, resets.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        flush;
  logic        clr_stats;
  logic [15:0] baud_div;
  logic [3:0]  fifo_count;
  logic [15:0] overrun_cnt;
  logic [15:0] parity_err_cnt;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .SYNC_LAT   (4),
    .DIV_MIN    (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .flush          (flush),
    .clr_stats      (clr_stats),
    .baud_div       (baud_div),
    .bus            (bus.master),
    .fifo_count     (fifo_count),
    .overrun_cnt    (overrun_cnt),
    .parity_err_cnt (parity_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         total = 0;
  int         bad = 0;
  logic [8:0] exp_q[$];
  int         pulse_q[$];
  int         m_cnt = 0;
  int         m_ovr = 0;
  int         m_par = 0;
  bit         m_en = 1'b0;
  int         c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Strobe timing and FIFO pop monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.rx_clk === 1'b1) begin
      chk("rx_clk_cyc", 32'(cyc), (pulse_q.size() > 0) ? 32'(pulse_q.pop_front()) : 32'hFFFF_FFFF);
    end
    if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
      if (exp_q.size() > 0) begin
        chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end else begin
        chk("rd_valid_extra", 32'(bus.rd_valid), 32'd0);
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_rx_en"},    32'(bus.rx_en),     32'd0);
    chk({tag, "_rx_clk"},   32'(bus.rx_clk),    32'd0);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready),  32'd0);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid),  32'd0);
    chk({tag, "_rd_data"},  32'(bus.rd_data),   32'd0);
    chk({tag, "_count"},    32'(fifo_count),    32'd0);
    chk({tag, "_ovr"},      32'(overrun_cnt),   32'd0);
    chk({tag, "_par"},      32'(parity_err_cnt), 32'd0);
  endtask

  // One-cycle stimulus beat; expected FIFO contents and counters are modelled here.
  task automatic xfer(input bit v, input logic [7:0] d, input bit f, input bit pop,
                      input bit fl, input bit clr);
    bit popping;
    bit acc;
    @(posedge clk); #1;
    bus.rx_valid      = v;
    bus.rx_data       = d;
    bus.rx_check_flag = f;
    bus.rd_ready      = pop;
    flush             = fl;
    clr_stats         = clr;
    popping = pop && (m_cnt > 0);
    acc     = v && m_en;
    if (fl) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (acc) begin
        if (m_cnt < DEPTH || popping) begin
          exp_q.push_back({f, d});
          m_cnt++;
        end else begin
          m_ovr++;
        end
      end
      if (popping) m_cnt--;
    end
    if (acc && f) m_par++;
    if (clr) begin
      m_ovr = 0;
      m_par = 0;
    end
    @(posedge clk); #1;
    bus.rx_valid  = 1'b0;
    bus.rd_ready  = 1'b0;
    flush         = 1'b0;
    clr_stats     = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; clr_stats = 1'b0; baud_div = 16'd100;
    bus.rx_clk_en = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    bus.rx_check_flag = 1'b0; bus.rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;

    @(posedge clk); #1;
    enable = 1'b1;
    chk("rx_en_lag", 32'(bus.rx_en), 32'd0);
    @(posedge clk); #1;
    m_en = 1'b1;
    chk("rx_en", 32'(bus.rx_en), 32'd1);
    chk("rx_ready", 32'(bus.rx_ready), 32'd1);

    // D=100: first strobe after 46 cycles, then every 100.
    @(posedge clk); #1;
    c = cyc;
    bus.rx_clk_en = 1'b1;
    pulse_q.push_back(c + 47); pulse_q.push_back(c + 147); pulse_q.push_back(c + 247);
    repeat (260) @(posedge clk);
    #1;
    bus.rx_clk_en = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    chk("pulses_d100", 32'(pulse_q.size()), 32'd0);

    // baud_div=5 clamps to 16; a mid-frame change to 200 waits for the next frame.
    baud_div = 16'd5;
    @(posedge clk); #1;
    c = cyc;
    bus.rx_clk_en = 1'b1;
    pulse_q.push_back(c + 5); pulse_q.push_back(c + 21);
    pulse_q.push_back(c + 37); pulse_q.push_back(c + 53);
    repeat (10) @(posedge clk);
    #1;
    baud_div = 16'd200;
    repeat (50) @(posedge clk);
    #1;
    bus.rx_clk_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pulses_d16", 32'(pulse_q.size()), 32'd0);
    c = cyc;
    bus.rx_clk_en = 1'b1;
    pulse_q.push_back(c + 97); pulse_q.push_back(c + 297);
    repeat (300) @(posedge clk);
    #1;
    bus.rx_clk_en = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("pulses_d200", 32'(pulse_q.size()), 32'd0);

    // Two bytes, second flagged, then pop them in order.
    xfer(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("count2", 32'(fifo_count), 32'(m_cnt));
    chk("head0", 32'(bus.rd_data), 32'h055);
    chk("par1", 32'(parity_err_cnt), 32'(m_par));
    xfer(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("head1", 32'(bus.rd_data), 32'h1A3);
    xfer(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("count0", 32'(fifo_count), 32'd0);
    chk("empty", 32'(bus.rd_valid), 32'd0);

    // Fill to depth, overrun once, then a ninth byte alongside a pop.
    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("count_full", 32'(fifo_count), 32'd8);
    xfer(1'b1, 8'h18, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("count_ovr", 32'(fifo_count), 32'd8);
    chk("ovr1", 32'(overrun_cnt), 32'd1);
    xfer(1'b1, 8'h19, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("count_popfull", 32'(fifo_count), 32'd8);
    chk("ovr_popfull", 32'(overrun_cnt), 32'(m_ovr));
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("count5", 32'(fifo_count), 32'(m_cnt));

    // Flush with a coincident push, then clear with a coincident flagged byte.
    xfer(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_valid", 32'(bus.rd_valid), 32'd0);
    chk("flush_ovr", 32'(overrun_cnt), 32'd1);
    xfer(1'b1, 8'hC4, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr_par", 32'(parity_err_cnt), 32'd0);
    chk("clr_ovr", 32'(overrun_cnt), 32'(m_ovr));
    chk("clr_head", 32'(bus.rd_data), 32'h1C4);
    xfer(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);

    // Enable dropped mid-frame: receiver resets, no further strobes, state retained.
    baud_div = 16'd100;
    @(posedge clk); #1;
    c = cyc;
    bus.rx_clk_en = 1'b1;
    pulse_q.push_back(c + 47);
    repeat (60) @(posedge clk);
    #1;
    enable = 1'b0;
    chk("rx_en_hold", 32'(bus.rx_en), 32'd1);
    @(posedge clk); #1;
    m_en = 1'b0;
    chk("rx_en_off", 32'(bus.rx_en), 32'd0);
    chk("rx_ready_off", 32'(bus.rx_ready), 32'd0);
    bus.rx_clk_en = 1'b0;
    xfer(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (150) @(posedge clk);
    #1;
    chk("pulses_dis", 32'(pulse_q.size()), 32'd0);
    chk("retain_count", 32'(fifo_count), 32'(m_cnt));
    chk("retain_par", 32'(parity_err_cnt), 32'(m_par));

    // Asynchronous reset in the middle of a frame.
    enable = 1'b1;
    @(posedge clk); #1;
    m_en = 1'b1;
    bus.rx_clk_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_reset("mid");
    enable = 1'b0;
    bus.rx_clk_en = 1'b0;
    m_en = 1'b0;
    exp_q.delete();
    m_cnt = 0; m_ovr = 0; m_par = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check_reset("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
